// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared FSM state encoding and bus-width constants for the external bus target.
package ext_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_HI = 2'd1,
        DATA    = 2'd2,
        RESP    = 2'd3
    } state_t;

    // The 32-bit address arrives as AE_PHASES consecutive 16-bit halves, low half first.
    localparam int unsigned AE_PHASES = 2;
    localparam int unsigned HALF_W    = 16;
    localparam int unsigned ADDR_W    = AE_PHASES * HALF_W;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WAIT_W    = 4;

endpackage

// File: rtl/ext_target_ram.sv
// ext_target_ram: single-port byte store, synchronous write and combinational read.
module ext_target_ram
    import ext_bus_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [BYTE_W-1:0]     wdata,
    output logic [BYTE_W-1:0]     rdata
);

    // NOTE: the array has no reset branch; contents must survive reset and a
    // reset loop over every word would also prevent mapping onto RAM cells.
    logic [BYTE_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ext_bus_target.sv
// ext_bus_target: byte target on a multiplexed 16-bit address/data bus with a two-phase address.
// Defining EXT_BUS_TARGET_WAIT_EN adds the WAIT_CFG input and 0..15 wait states before the response.
module ext_bus_target
    import ext_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned       DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
`ifdef EXT_BUS_TARGET_WAIT_EN
    input  logic [WAIT_W-1:0] WAIT_CFG,
`endif
    input  logic              MEM_READ,
    input  logic              MEM_WRITE,
    input  logic              AE,
    input  logic              DOE,
    input  logic [HALF_W-1:0] AD_IN,
    output logic [BYTE_W-1:0] AD_OUT,
    output logic              MEM_READY,
    output logic              SEL,
    output logic              ERR
);

    state_t                state;
    state_t                state_nxt;
    logic [HALF_W-1:0]     addr_lo;
    logic [ADDR_W-1:0]     addr_full;
    logic [ADDR_W-1:0]     offset;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [BYTE_W-1:0]     ram_rdata;
    logic [BYTE_W-1:0]     rdata_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_cnt_nxt;
    logic [WAIT_W-1:0]     wait_load;
    logic                  load_lo;
    logic                  load_hi;
    logic                  err_nxt;
    logic                  err_q;
    logic                  wr_req;
    logic                  ram_we;

`ifdef EXT_BUS_TARGET_WAIT_EN
    assign wait_load = WAIT_CFG;
`else
    assign wait_load = '0;
`endif

    // Offset is unsigned, so addresses below ADDR_BASE wrap to huge values and miss.
    assign addr_full = {AD_IN, addr_lo};
    assign offset    = addr_full - ADDR_BASE;
    assign hit       = (offset >> DEPTH_LOG2) == '0;

    // The address phase reads the new location; RESP writes the latched one.
    assign ram_addr  = (state == RESP) ? addr_q : offset[DEPTH_LOG2-1:0];

    // A reset edge that coincides with RESP must not commit the write.
    assign ram_we    = wr_req & ~rst;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        load_lo      = 1'b0;
        load_hi      = 1'b0;
        err_nxt      = 1'b0;
        wr_req       = 1'b0;

        case (state)
            IDLE: begin
                if (AE) begin
                    load_lo   = 1'b1;
                    state_nxt = ADDR_HI;
                end
            end

            ADDR_HI: begin
                if (!AE) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (!hit) begin
                    state_nxt = IDLE;
                end else begin
                    load_hi      = 1'b1;
                    wait_cnt_nxt = wait_load;
                    state_nxt    = (wait_load == '0) ? RESP : DATA;
                end
            end

            DATA: begin
                if (AE) begin
                    err_nxt      = 1'b1;
                    load_lo      = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = ADDR_HI;
                end else if (wait_cnt <= WAIT_W'(1)) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                end
            end

            RESP: begin
                state_nxt = IDLE;
                if (AE) begin
                    err_nxt   = 1'b1;
                    load_lo   = 1'b1;
                    state_nxt = ADDR_HI;
                end else if (MEM_READ && MEM_WRITE) begin
                    err_nxt = 1'b1;
                end else if (MEM_WRITE) begin
                    if (DOE) begin
                        wr_req = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (!MEM_READ) begin
                    err_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_lo  <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
            if (load_lo) begin
                addr_lo <= AD_IN;
            end
            if (load_hi) begin
                addr_q  <= offset[DEPTH_LOG2-1:0];
                rdata_q <= ram_rdata;
            end
        end
    end

    ext_target_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (AD_IN[BYTE_W-1:0]),
        .rdata (ram_rdata)
    );

    // Only in-window transactions ever reach DATA or RESP.
    assign MEM_READY = (state == RESP);
    assign SEL       = (state == DATA) || (state == RESP);
    assign AD_OUT    = (MEM_READY && MEM_READ && !MEM_WRITE) ? rdata_q : '0;
    assign ERR       = err_q;

endmodule

// File: tb/tb_ext_bus_target.sv
// tb_ext_bus_target: two targets (bases 0x0 and 0x1_0000) share one bus; directed table,
// hand sequences for abort and reset, then random traffic against a transaction-level model.
module tb_ext_bus_target;

    localparam logic [31:0] BASE0      = 32'h0000_0000;
    localparam logic [31:0] BASE1      = 32'h0001_0000;
    localparam int          DEPTH_LOG2 = 10;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic        ae;
    logic        doe;
    logic [15:0] ad_in;
    logic [7:0]  ad_out0, ad_out1;
    logic        mem_ready0, mem_ready1;
    logic        sel0, sel1;
    logic        err0, err1;
`ifdef EXT_BUS_TARGET_WAIT_EN
    logic [3:0]  wait_cfg;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int tag      = 0;
    int waits    = 0;
    bit pend_err0 = 1'b0;
    bit pend_err1 = 1'b0;

    // Transaction-level model state: byte contents and which bytes have been written.
    logic [7:0] mem_m   [2][DEPTH];
    bit         known_m [2][DEPTH];

    typedef struct {
        logic [31:0]     addr;
        bit              rd;
        bit              wr;
        bit              doe;
        bit              trunc;
        logic [7:0]      wdata;
        logic [1:0]      rdy;
        logic [1:0][7:0] dout;
        logic [1:0]      chk;
        logic [1:0]      err;
    } vec_t;

    always #5 clk = ~clk;

    ext_bus_target #(.ADDR_BASE(BASE0), .DEPTH_LOG2(DEPTH_LOG2)) dut0 (
        .clk       (clk),
        .rst       (rst),
`ifdef EXT_BUS_TARGET_WAIT_EN
        .WAIT_CFG  (wait_cfg),
`endif
        .MEM_READ  (mem_read),
        .MEM_WRITE (mem_write),
        .AE        (ae),
        .DOE       (doe),
        .AD_IN     (ad_in),
        .AD_OUT    (ad_out0),
        .MEM_READY (mem_ready0),
        .SEL       (sel0),
        .ERR       (err0)
    );

    ext_bus_target #(.ADDR_BASE(BASE1), .DEPTH_LOG2(DEPTH_LOG2)) dut1 (
        .clk       (clk),
        .rst       (rst),
`ifdef EXT_BUS_TARGET_WAIT_EN
        .WAIT_CFG  (wait_cfg),
`endif
        .MEM_READ  (mem_read),
        .MEM_WRITE (mem_write),
        .AE        (ae),
        .DOE       (doe),
        .AD_IN     (ad_in),
        .AD_OUT    (ad_out1),
        .MEM_READY (mem_ready1),
        .SEL       (sel1),
        .ERR       (err1)
    );

`ifdef EXT_BUS_TARGET_WAIT_EN
    assign wait_cfg = waits[3:0];
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (txn %0d, t=%0t): got %h, expected %h", name, tag, $time, act, exp);
        end
    endtask

    // Checks one bus cycle at the falling edge, then advances to just after the next rising edge.
    task automatic cyc_check(input bit r0, input bit r1, input bit s0, input bit s1,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input bit c0, input bit c1, input bit e0, input bit e1);
        @(negedge clk);
        check("MEM_READY/base0", {31'd0, mem_ready0}, {31'd0, r0});
        check("MEM_READY/base1", {31'd0, mem_ready1}, {31'd0, r1});
        check("SEL/base0",       {31'd0, sel0},       {31'd0, s0});
        check("SEL/base1",       {31'd0, sel1},       {31'd0, s1});
        check("ERR/base0",       {31'd0, err0},       {31'd0, e0});
        check("ERR/base1",       {31'd0, err1},       {31'd0, e1});
        if (c0) check("AD_OUT/base0", {24'd0, ad_out0}, {24'd0, d0});
        if (c1) check("AD_OUT/base1", {24'd0, ad_out1}, {24'd0, d1});
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input bit rd, input bit wr, input bit dv,
                                input bit trunc, input logic [7:0] wdata,
                                input bit r0, input bit r1, input logic [7:0] d0,
                                input logic [7:0] d1, input bit e0, input bit e1);
        vec_t v;
        v.addr  = addr;  v.rd = rd;  v.wr = wr;  v.doe = dv;  v.trunc = trunc;
        v.wdata = wdata;
        v.rdy   = {r1, r0};
        v.dout  = {d1, d0};
        v.chk   = 2'b11;
        v.err   = {e1, e0};
        return v;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? BASE0 : BASE1;
    endfunction

    // Expected response of each target, straight from the bus rules.
    function automatic vec_t predict(input logic [31:0] addr, input bit rd, input bit wr,
                                     input bit dv, input bit trunc, input logic [7:0] wdata);
        vec_t        v;
        logic [31:0] off;
        bit          hit;
        bit          rd_only;
        v = mk(addr, rd, wr, dv, trunc, wdata, 0, 0, 8'h00, 8'h00, 0, 0);
        for (int k = 0; k < 2; k++) begin
            off     = addr - base_of(k);
            hit     = off < DEPTH;
            rd_only = rd && !wr;
            v.rdy[k]  = hit && !trunc;
            v.err[k]  = trunc || (hit && ((rd && wr) || (wr && !dv) || (!rd && !wr)));
            v.dout[k] = (v.rdy[k] && rd_only) ? mem_m[k][off[DEPTH_LOG2-1:0]] : 8'h00;
            v.chk[k]  = !(v.rdy[k] && rd_only) || known_m[k][off[DEPTH_LOG2-1:0]];
        end
        return v;
    endfunction

    function automatic void model_commit(input vec_t v);
        logic [31:0] off;
        for (int k = 0; k < 2; k++) begin
            off = v.addr - base_of(k);
            if (off < DEPTH && !v.trunc && v.wr && !v.rd && v.doe) begin
                mem_m[k][off[DEPTH_LOG2-1:0]]   = v.wdata;
                known_m[k][off[DEPTH_LOG2-1:0]] = 1'b1;
            end
        end
    endfunction

    // One complete transaction, back-to-back with whatever follows.
    task automatic run_txn(input vec_t v);
        tag++;
        ae = 1'b1;  ad_in = v.addr[15:0];  mem_read = v.rd;  mem_write = v.wr;  doe = 1'b0;
        cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, pend_err0, pend_err1);
        pend_err0 = 1'b0;
        pend_err1 = 1'b0;
        ae = !v.trunc;  ad_in = v.addr[31:16];
        cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        ae = 1'b0;
        if (v.trunc) begin
            ad_in = 16'h0000;
            cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, v.err[0], v.err[1]);
        end else begin
            ad_in = {8'h00, v.wdata};  doe = v.doe;
            for (int w = 0; w < waits; w++) begin
                cyc_check(0, 0, v.rdy[0], v.rdy[1], 8'h00, 8'h00, 1, 1, 0, 0);
            end
            cyc_check(v.rdy[0], v.rdy[1], v.rdy[0], v.rdy[1], v.dout[0], v.dout[1],
                      v.chk[0], v.chk[1], 0, 0);
            pend_err0 = v.err[0];
            pend_err1 = v.err[1];
        end
        model_commit(v);
    endtask

    task automatic idle_cycle();
        ae = 1'b0;  mem_read = 1'b0;  mem_write = 1'b0;  doe = 1'b0;  ad_in = 16'h0000;
        cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, pend_err0, pend_err1);
        pend_err0 = 1'b0;
        pend_err1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [$];
        vec_t        v;
        logic [31:0] addr;
        int          kind;
        int          off;
        bit          rd, wr, dv, trunc;

        foreach (known_m[k, i]) known_m[k][i] = 1'b0;

        // addr, rd, wr, doe, trunc, wdata, rdy0, rdy1, dout0, dout1, err0, err1
        tbl.push_back(mk(32'h0000_0010, 0, 1, 1, 0, 8'h5A, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0000_0010, 1, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0001_0010, 0, 1, 1, 0, 8'h77, 0, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0001_0010, 1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h77, 0, 0));
        tbl.push_back(mk(32'h0000_0010, 1, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0000_0010, 1, 0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1));
        tbl.push_back(mk(32'h0000_0010, 0, 1, 0, 0, 8'h11, 1, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(32'h0000_0010, 1, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0000_0010, 1, 1, 1, 0, 8'h22, 1, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(32'h0000_0010, 1, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0000_0010, 0, 0, 1, 0, 8'h33, 1, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(32'h0000_03FF, 0, 1, 1, 0, 8'hC3, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0000_0400, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0000_03FF, 1, 0, 0, 0, 8'h00, 1, 0, 8'hC3, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0001_03FF, 0, 1, 1, 0, 8'h3C, 0, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0001_0400, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0001_03FF, 1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h3C, 0, 0));
        tbl.push_back(mk(32'h0000_FFFF, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 8'hA0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0000_0001, 0, 1, 1, 0, 8'hA1, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0000_0000, 1, 0, 0, 0, 8'h00, 1, 0, 8'hA0, 8'h00, 0, 0));
        tbl.push_back(mk(32'h0000_0001, 1, 0, 0, 0, 8'h00, 1, 0, 8'hA1, 8'h00, 0, 0));

        // Reset state, observed while reset is held.
        rst = 1'b1;  ae = 1'b0;  mem_read = 1'b0;  mem_write = 1'b0;  doe = 1'b0;  ad_in = '0;
        @(posedge clk);
        #1;
        cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        rst = 1'b0;
        idle_cycle();

        foreach (tbl[i]) run_txn(tbl[i]);
        idle_cycle();

        // Abort: AE rises during RESP of a write; the write is dropped, ERR pulses,
        // and the new address completes as a read of the old contents.
        tag++;
        ae = 1'b1;  ad_in = 16'h0010;  mem_write = 1'b1;  mem_read = 1'b0;  doe = 1'b0;
        cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        ad_in = 16'h0000;
        cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        ad_in = 16'h0010;  doe = 1'b1;
        cyc_check(1, 0, 1, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        ad_in = 16'h0000;  mem_write = 1'b0;  mem_read = 1'b1;  doe = 1'b0;
        cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0);
        ae = 1'b0;
        cyc_check(1, 0, 1, 0, 8'h5A, 8'h00, 1, 1, 0, 0);
        idle_cycle();

        // Reset during a write of 0xFF: outputs clear next cycle, location keeps 0x5A.
        tag++;
`ifdef EXT_BUS_TARGET_WAIT_EN
        waits = 3;
`endif
        ae = 1'b1;  ad_in = 16'h0010;  mem_write = 1'b1;  mem_read = 1'b0;  doe = 1'b0;
        cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        ad_in = 16'h0000;
        cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        ae = 1'b0;  ad_in = 16'h00FF;  doe = 1'b1;  rst = 1'b1;
        cyc_check(waits == 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        rst = 1'b0;  mem_write = 1'b0;  doe = 1'b0;  ad_in = 16'h0000;
        cyc_check(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        waits = 0;
        run_txn(mk(32'h0000_0010, 1, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 8'h00, 0, 0));

`ifdef EXT_BUS_TARGET_WAIT_EN
        // Three wait states: MEM_READY lands in the sixth cycle after AE rises.
        waits = 3;
        run_txn(mk(32'h0001_0010, 1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h77, 0, 0));
        waits = 0;
`endif

        // Random traffic against the model.
        for (int n = 0; n < 200; n++) begin
            off = $urandom_range(0, 1) ? $urandom_range(0, 15) : DEPTH - 16 + $urandom_range(0, 15);
            case ($urandom_range(0, 4))
                0:       addr = BASE0 + off;
                1:       addr = BASE1 + off;
                2:       addr = BASE0 + DEPTH + off;
                3:       addr = BASE1 - 1 - off;
                default: addr = $urandom;
            endcase
            kind  = $urandom_range(0, 9);
            rd    = (kind <= 3) || (kind == 8);
            wr    = (kind >= 4) && (kind <= 8);
            dv    = (kind != 7);
            trunc = ($urandom_range(0, 15) == 0);
`ifdef EXT_BUS_TARGET_WAIT_EN
            waits = $urandom_range(0, 4);
`endif
            v = predict(addr, rd, wr, dv, trunc, 8'($urandom));
            run_txn(v);
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_bus_target.md
EXT_BUS_TARGET -- requirements
Module: ext_bus_target

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000: first byte address served by this target.
REQ-002 Parameter DEPTH_LOG2, default 10: target holds 2^DEPTH_LOG2 bytes.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 MEM_READ  in  1  initiator read request, held for the whole transaction.
REQ-007 MEM_WRITE  in  1  initiator write request, held for the whole transaction.
REQ-008 AE  in  1  address enable; high for exactly two consecutive cycles (low half, then high half).
REQ-009 DOE  in  1  initiator drives write data on AD_IN[7:0].
REQ-010 AD_IN  in  16  multiplexed address/data from the initiator.
REQ-011 AD_OUT  out  8  read data returned to the initiator.
REQ-012 MEM_READY  out  1  data-phase completion strobe.
REQ-013 SEL  out  1  the current transaction hits this target's window.
REQ-014 ERR  out  1  one-cycle pulse on a protocol violation.

Function
REQ-015 FSM states: IDLE, ADDR_HI, DATA, RESP.
- IDLE: AE=1 latches AD_IN into addr_lo and moves to ADDR_HI.
- ADDR_HI: AE=1 forms addr={AD_IN,addr_lo}.
  - In window: registers mem[addr-ADDR_BASE] into rdata_q, loads the wait counter and moves to DATA.
  - Out of window: returns to IDLE with SEL=0.
- ADDR_HI with AE=0: pulses ERR and returns to IDLE.
REQ-016 DATA SHALL decrement the wait counter each cycle and move to RESP when the counter is 0.
- With zero waits, RESP is entered directly from ADDR_HI.
- In that case MEM_READY is high in the third cycle after AE first rises.
REQ-017 RESP SHALL hold MEM_READY=1 for exactly one cycle and then return to IDLE; MEM_READY is 0 in all other states.
REQ-018 Reads: AD_OUT SHALL equal rdata_q whenever MEM_READY=1 and MEM_READ=1, and 8'h00 otherwise.
REQ-019 Writes: in RESP, with MEM_WRITE=1 and DOE=1, AD_IN[7:0] SHALL be written to mem at the clock edge ending RESP.
- DOE=0 in RESP suppresses the write and pulses ERR.
REQ-020 If MEM_READ and MEM_WRITE are both 1 in RESP: no write, AD_OUT=8'h00, ERR pulses, MEM_READY is still asserted so the initiator cannot hang.
REQ-021 If MEM_READ and MEM_WRITE are both 0 on reaching RESP: MEM_READY is asserted, no access is made, ERR pulses.
REQ-022 SEL SHALL be 1 from DATA entry through RESP for in-window transactions.
REQ-023 Window check: addr-ADDR_BASE < 2^DEPTH_LOG2, computed unsigned on 32 bits; addresses below ADDR_BASE wrap to large values and miss.
REQ-024 AE=1 seen in DATA or RESP SHALL abort the transaction: ERR pulses, no write, state goes to ADDR_HI with the new low half latched.
REQ-025 Back-to-back: AE may rise in the cycle after RESP; IDLE accepts it with no dead cycle.

Reset
REQ-026 Reset SHALL force state=IDLE, MEM_READY=0, AD_OUT=8'h00, SEL=0, ERR=0, addr_lo=0, rdata_q=0 and wait counter=0.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset in any state SHALL abandon the transaction without writing memory.

Configuration
REQ-029 Macro EXT_BUS_TARGET_WAIT_EN defined: input port WAIT_CFG (in, 4 bits) is present.
- It is sampled on the ADDR_HI->DATA transition.
- It inserts WAIT_CFG cycles in DATA before RESP (0..15).
REQ-030 EXT_BUS_TARGET_WAIT_EN undefined: no WAIT_CFG port and zero wait states; DATA is never occupied.

Structure
REQ-031 A shared package ext_bus_pkg SHALL hold the state encoding (2 bits: IDLE=0, ADDR_HI=1, DATA=2, RESP=3) and the AE phase-count constant (2).
REQ-032 Byte storage SHALL be a sub-module ext_target_ram: single port, synchronous write, combinational read, DEPTH_LOG2 address bits.

Verification
REQ-033 Write then read: write 0x5A to 0x0000_0010, then read it back.
- Response: MEM_READY high one cycle in each transaction, then AD_OUT=0x5A on the read's MEM_READY cycle.
REQ-034 High-half check: pre-load 0x0001_0010=0x77 with ADDR_BASE=0x0001_0000, then read 0x0001_0010.
- Response: AD_OUT=0x77, SEL=1.
- A read of 0x0000_0010 gets no MEM_READY and SEL=0.
REQ-035 Truncated address: AE drops after one cycle.
- Response: ERR=1 for one cycle, state IDLE, no MEM_READY.
REQ-036 Wait states (macro defined): WAIT_CFG=3 on a read.
- Response: MEM_READY in cycle 6 after AE rises, and high for exactly one cycle.
REQ-037 Reset and back-to-back:
- rst asserted in DATA during a write of 0xFF: the target location keeps its old value and outputs return to reset values next cycle.
- Two back-to-back reads of 0x0 and 0x1: both complete in 3 cycles each.
